io_credit_ctrl: RTL and testbench

IO_CREDIT_CTRL -- requirements
Module: io_credit_ctrl

---
 rtl/io_credit_pkg.sv | 22 ++
 rtl/bin2bcd8.sv | 20 ++
 rtl/io_credit_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_io_credit_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_credit_pkg.sv
// Shared types and register-map constants for the coin/credit I/O controller.
package io_credit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_COIN,
        ST_START,
        ST_PUBLISH
    } state_t;

    localparam int unsigned ADDR_CRED_ONES = 0;
    localparam int unsigned ADDR_CRED_TENS = 1;
    localparam int unsigned ADDR_STATUS    = 2;
    localparam int unsigned ADDR_STARTS    = 3;
    localparam int unsigned ADDR_CTRL_BASE = 4;
    localparam int unsigned ADDR_EDGE_BASE = 16;

    // Wide enough for the longest phase (publish runs up to 20 steps).
    localparam int unsigned STEP_W = 5;

endpackage

// File: rtl/bin2bcd8.sv
// Binary to two-digit BCD {tens, ones}; valid for inputs 0..99.
module bin2bcd8 (
    input  logic [7:0] bin,
    output logic [7:0] bcd
);

    logic [15:0] sh;

    // Double dabble with only the tens and ones digits kept.
    always_comb begin
        sh = {8'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8] >= 4'd5)  sh[11:8]  = sh[11:8] + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            sh = {sh[14:0], 1'b0};
        end
        bcd = sh[15:8];
    end

endmodule

// File: rtl/io_credit_ctrl.sv
// Frame-driven coin/credit/start controller publishing a nibble register map
// that the CPU reads and writes through a one-cycle-latency port.
module io_credit_ctrl
    import io_credit_pkg::*;
#(
    parameter int unsigned NPLAYER  = 2,
    parameter int unsigned NCOIN    = 2,
    parameter int unsigned CTLW     = 6,
    parameter int unsigned MAXCRED  = 99,
    parameter int unsigned REGDEPTH = 64
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        UPDATE,
    input  logic                        ENABLE,
    input  logic                        WR,
    input  logic [$clog2(REGDEPTH)-1:0] ADRS,
    input  logic [3:0]                  IN,
    output logic [7:0]                  OUT,
    input  logic [NPLAYER*CTLW-1:0]     CTRL,
    input  logic [NPLAYER-1:0]          START,
    input  logic [NCOIN-1:0]            COIN,
    input  logic                        SERVICE,
    input  logic [NCOIN*4-1:0]          COINCFG,
    input  logic                        FREEPLAY,
    output logic [7:0]                  CREDITS,
    output logic [7:0]                  CRED_BCD,
    output logic                        LOCKOUT,
    output logic                        BUSY
);

    localparam int unsigned AW   = $clog2(REGDEPTH);
    localparam int unsigned CW   = NPLAYER * CTLW;
    localparam int unsigned NPUB = 4 + 4 * NPLAYER;

    state_t              state;
    logic [STEP_W-1:0]   step;
    logic                update_q;
    logic                busy;
    logic [7:0]          credits;
    logic [1:0]          coin_cnt [NCOIN];
    logic [CW-1:0]       ctrl_prev, ctrl_cur, ctrl_rise;
    logic [NPLAYER-1:0]  start_prev, start_rise, accepted;
    logic [NCOIN-1:0]    coin_prev, coin_cur, coin_rise;
    logic                svc_prev, svc_cur, svc_rise;
    logic [3:0]          regs [REGDEPTH];
    logic [7:0]          out_q;

    logic [3:0]          cfg_sel;
    logic [1:0]          cnt_sel;
    logic                coin_rise_sel, start_rise_sel, start_ok;
    logic [7:0]          add_amt, sum, sat_sum, cost_sel;
    logic [STEP_W-1:0]   k;
    logic [7:0]          ctrl_byte;
    logic [AW-1:0]       pub_addr;
    logic [3:0]          pub_data;
    logic                pub_we;
    logic [7:0]          bcd;

    bin2bcd8 u_bcd (
        .bin (credits),
        .bcd (bcd)
    );

    // Per-step selection of the slot/player under service and the saturating credit sum.
    always_comb begin
        cfg_sel        = '0;
        cnt_sel        = '0;
        coin_rise_sel  = 1'b0;
        start_rise_sel = 1'b0;
        cost_sel       = '0;
        for (int unsigned s = 0; s < NCOIN; s++) begin
            if (step == STEP_W'(s)) begin
                cfg_sel       = COINCFG[4*s +: 4];
                cnt_sel       = coin_cnt[s];
                coin_rise_sel = coin_rise[s];
            end
        end
        for (int unsigned p = 0; p < NPLAYER; p++) begin
            if (step == STEP_W'(p)) begin
                start_rise_sel = start_rise[p];
                cost_sel       = 8'(p + 1);
            end
        end
        add_amt  = (step == STEP_W'(NCOIN)) ? 8'd1 : (8'(cfg_sel[1:0]) + 8'd1);
        sum      = credits + add_amt;
        sat_sum  = (sum > 8'(MAXCRED)) ? 8'(MAXCRED) : sum;
        start_ok = start_rise_sel && (FREEPLAY || (credits >= cost_sel));
    end

    // Publish step -> register address and nibble.
    always_comb begin
        pub_addr  = '0;
        pub_data  = '0;
        k         = '0;
        ctrl_byte = '0;
        if (step == STEP_W'(0)) begin
            pub_addr = AW'(ADDR_CRED_ONES);
            pub_data = bcd[3:0];
        end else if (step == STEP_W'(1)) begin
            pub_addr = AW'(ADDR_CRED_TENS);
            pub_data = bcd[7:4];
        end else if (step == STEP_W'(2)) begin
            pub_addr = AW'(ADDR_STATUS);
            pub_data = {svc_cur, 1'b0, 2'(coin_cur)};
        end else if (step == STEP_W'(3)) begin
            pub_addr = AW'(ADDR_STARTS);
            pub_data = 4'(accepted);
        end else if (step < STEP_W'(4 + 2 * NPLAYER)) begin
            k        = step - STEP_W'(4);
            pub_addr = AW'(ADDR_CTRL_BASE) + AW'(k);
            for (int unsigned p = 0; p < NPLAYER; p++) begin
                if (k[STEP_W-1:1] == (STEP_W-1)'(p)) ctrl_byte = 8'(ctrl_cur[p*CTLW +: CTLW]);
            end
            pub_data = k[0] ? ctrl_byte[7:4] : ctrl_byte[3:0];
        end else begin
            k        = step - STEP_W'(4 + 2 * NPLAYER);
            pub_addr = AW'(ADDR_EDGE_BASE) + AW'(k);
            for (int unsigned p = 0; p < NPLAYER; p++) begin
                if (k[STEP_W-1:1] == (STEP_W-1)'(p)) ctrl_byte = 8'(ctrl_rise[p*CTLW +: CTLW]);
            end
            pub_data = k[0] ? ctrl_byte[7:4] : ctrl_byte[3:0];
        end
        pub_we = (state == ST_PUBLISH) && !ENABLE;
    end

    // Update sequencer: sample, coins + service, starts, publish.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            step       <= '0;
            update_q   <= 1'b0;
            busy       <= 1'b0;
            credits    <= '0;
            ctrl_prev  <= '0;
            ctrl_cur   <= '0;
            ctrl_rise  <= '0;
            start_prev <= '0;
            start_rise <= '0;
            accepted   <= '0;
            coin_prev  <= '0;
            coin_cur   <= '0;
            coin_rise  <= '0;
            svc_prev   <= 1'b0;
            svc_cur    <= 1'b0;
            svc_rise   <= 1'b0;
            for (int unsigned s = 0; s < NCOIN; s++) coin_cnt[s] <= '0;
        end else begin
            update_q <= UPDATE;
            case (state)
                ST_IDLE: begin
                    if (UPDATE && !update_q) begin
                        state <= ST_SAMPLE;
                        busy  <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    ctrl_cur   <= CTRL;
                    ctrl_rise  <= CTRL & ~ctrl_prev;
                    ctrl_prev  <= CTRL;
                    start_rise <= START & ~start_prev;
                    start_prev <= START;
                    coin_cur   <= COIN;
                    coin_rise  <= COIN & ~coin_prev;
                    coin_prev  <= COIN;
                    svc_cur    <= SERVICE;
                    svc_rise   <= SERVICE & ~svc_prev;
                    svc_prev   <= SERVICE;
                    accepted   <= '0;
                    step       <= '0;
                    state      <= ST_COIN;
                end
                ST_COIN: begin
                    if (step == STEP_W'(NCOIN)) begin
                        if (svc_rise) credits <= sat_sum;
                        step  <= '0;
                        state <= ST_START;
                    end else begin
                        for (int unsigned s = 0; s < NCOIN; s++) begin
                            if (step == STEP_W'(s) && coin_rise_sel) begin
                                if (cnt_sel == cfg_sel[3:2]) begin
                                    coin_cnt[s] <= '0;
                                    credits     <= sat_sum;
                                end else begin
                                    coin_cnt[s] <= cnt_sel + 2'd1;
                                end
                            end
                        end
                        step <= step + STEP_W'(1);
                    end
                end
                ST_START: begin
                    if (start_ok) begin
                        accepted <= accepted | (NPLAYER'(1) << step);
                        if (!FREEPLAY) credits <= credits - cost_sel;
                    end
                    if (step == STEP_W'(NPLAYER - 1)) begin
                        step  <= '0;
                        state <= ST_PUBLISH;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                ST_PUBLISH: begin
                    // CPU access has priority; the publish pointer waits.
                    if (!ENABLE) begin
                        if (step == STEP_W'(NPUB - 1)) begin
                            step  <= '0;
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            step <= step + STEP_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Nibble register file: CPU port returns the pre-write value one cycle later.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < REGDEPTH; i++) regs[i] <= '0;
            out_q <= 8'hF0;
        end else if (ENABLE) begin
            out_q <= {4'hF, regs[ADRS]};
            if (WR) regs[ADRS] <= IN;
        end else if (pub_we) begin
            regs[pub_addr] <= pub_data;
        end
    end

    assign OUT      = out_q;
    assign CREDITS  = credits;
    assign CRED_BCD = bcd;
    assign LOCKOUT  = (credits == 8'(MAXCRED));
    assign BUSY     = busy;

endmodule

// File: tb/tb_io_credit_ctrl.sv
// Directed bench for io_credit_ctrl at default parameters.
module tb_io_credit_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        UPDATE, ENABLE, WR;
    logic [5:0]  ADRS;
    logic [3:0]  IN;
    logic [7:0]  OUT;
    logic [11:0] CTRL;
    logic [1:0]  START, COIN;
    logic        SERVICE;
    logic [7:0]  COINCFG;
    logic        FREEPLAY;
    logic [7:0]  CREDITS, CRED_BCD;
    logic        LOCKOUT, BUSY;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    io_credit_ctrl dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .UPDATE   (UPDATE),
        .ENABLE   (ENABLE),
        .WR       (WR),
        .ADRS     (ADRS),
        .IN       (IN),
        .OUT      (OUT),
        .CTRL     (CTRL),
        .START    (START),
        .COIN     (COIN),
        .SERVICE  (SERVICE),
        .COINCFG  (COINCFG),
        .FREEPLAY (FREEPLAY),
        .CREDITS  (CREDITS),
        .CRED_BCD (CRED_BCD),
        .LOCKOUT  (LOCKOUT),
        .BUSY     (BUSY)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_read(input logic [5:0] a, output logic [7:0] d);
        ENABLE = 1'b1; WR = 1'b0; ADRS = a;
        tick();
        d = OUT;
        ENABLE = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [5:0] a, input logic [3:0] exp);
        logic [7:0] d;
        cpu_read(a, d);
        check(tag, d, {4'hF, exp});
    endtask

    // Pulse UPDATE, wait for the update to finish, and check the busy window length.
    task automatic run_update(input string tag);
        int n;
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        n = 0;
        while (BUSY === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check(tag, 8'(n), 8'd18);
    endtask

    initial begin
        int n;
        RESET_N = 1'b0; UPDATE = 1'b0; ENABLE = 1'b0; WR = 1'b0; ADRS = '0; IN = '0;
        CTRL = '0; START = '0; COIN = '0; SERVICE = 1'b0; COINCFG = 8'h04; FREEPLAY = 1'b0;
        #12;
        check("rst_out", OUT, 8'hF0);
        check("rst_credits", CREDITS, 8'd0);
        check("rst_busy", {7'd0, BUSY}, 8'd0);
        check("rst_lockout", {7'd0, LOCKOUT}, 8'd0);
        RESET_N = 1'b1;
        tick();
        check_reg("rst_reg05", 6'h05, 4'h0);

        // CPU write returns the pre-write value, then the new value on readback.
        ENABLE = 1'b1; WR = 1'b1; ADRS = 6'h3F; IN = 4'hC;
        tick();
        ENABLE = 1'b0; WR = 1'b0;
        check("cpu_prewrite", OUT, 8'hF0);
        check_reg("cpu_readback", 6'h3F, 4'hC);

        // Two coins per credit on slot 0; slot 1 is one coin per credit.
        COIN = 2'b01;
        run_update("busy_u1");
        check("coin1_credits", CREDITS, 8'd0);
        COIN = 2'b00;
        run_update("busy_u2");
        COIN = 2'b01; CTRL = {6'h15, 6'h2A};
        run_update("busy_u3");
        check("coin2_credits", CREDITS, 8'd1);
        check_reg("coin2_reg0", 6'h00, 4'h1);
        check_reg("coin2_reg1", 6'h01, 4'h0);
        check_reg("coin2_reg2", 6'h02, 4'h1);
        check_reg("ctrl_p0_lo", 6'h04, 4'hA);
        check_reg("ctrl_p0_hi", 6'h05, 4'h2);
        check_reg("ctrl_p1_lo", 6'h06, 4'h5);
        check_reg("ctrl_p1_hi", 6'h07, 4'h1);
        check_reg("rise_p1_lo", 6'h12, 4'h5);
        COIN = 2'b00;
        run_update("busy_u4");
        check_reg("rise_p0_held", 6'h10, 4'h0);
        check_reg("ctrl_p0_held", 6'h04, 4'hA);
        check_reg("status_idle", 6'h02, 4'h0);

        // Service plus slot 1 coin in the same frame.
        SERVICE = 1'b1; COIN = 2'b10;
        run_update("busy_u5");
        check("svc_credits", CREDITS, 8'd3);
        check("svc_bcd", CRED_BCD, 8'h03);
        check_reg("svc_status", 6'h02, 4'hA);
        SERVICE = 1'b0; COIN = 2'b00; CTRL = '0;
        run_update("busy_u6");

        // Player 1 start costs 2 credits.
        START = 2'b10;
        run_update("busy_u7");
        check("p1_start_credits", CREDITS, 8'd1);
        check_reg("p1_start_flags", 6'h03, 4'h2);
        START = 2'b00;
        run_update("busy_u8");
        START = 2'b10;
        run_update("busy_u9");
        check("p1_reject_credits", CREDITS, 8'd1);
        check_reg("p1_reject_flags", 6'h03, 4'h0);
        START = 2'b00;
        run_update("busy_u10");
        START = 2'b01;
        run_update("busy_u11");
        check("p0_start_credits", CREDITS, 8'd0);
        check_reg("p0_start_flags", 6'h03, 4'h1);
        START = 2'b00;
        run_update("busy_u12");

        // Free play accepts with no credits.
        FREEPLAY = 1'b1; START = 2'b01;
        run_update("busy_u13");
        check("free_credits", CREDITS, 8'd0);
        check_reg("free_flags", 6'h03, 4'h1);
        FREEPLAY = 1'b0; START = 2'b00;
        run_update("busy_u14");

        // Fill to 98 with 1-coin/4-credit slots, then saturate at 99.
        COINCFG = 8'h33;
        for (int i = 0; i < 10; i++) begin
            COIN = 2'b11; SERVICE = 1'b1;
            run_update("busy_fill");
            COIN = 2'b00; SERVICE = 1'b0;
            run_update("busy_fill_rel");
        end
        check("fill90_credits", CREDITS, 8'd90);
        check("fill90_bcd", CRED_BCD, 8'h90);
        COIN = 2'b11;
        run_update("busy_fill98");
        COIN = 2'b00;
        run_update("busy_fill98_rel");
        check("fill98_credits", CREDITS, 8'd98);
        check("fill98_lockout", {7'd0, LOCKOUT}, 8'd0);
        COIN = 2'b01;
        run_update("busy_sat");
        check("sat_credits", CREDITS, 8'd99);
        check("sat_lockout", {7'd0, LOCKOUT}, 8'd1);
        check("sat_bcd", CRED_BCD, 8'h99);
        check_reg("sat_reg0", 6'h00, 4'h9);
        check_reg("sat_reg1", 6'h01, 4'h9);

        // Five cycles of CPU access during publish stretch the busy window by five.
        COIN = 2'b00;
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        n = 0;
        repeat (6) begin n++; tick(); end
        ENABLE = 1'b1; WR = 1'b1; ADRS = 6'h20; IN = 4'hA;
        n++; tick();
        WR = 1'b0;
        n++; tick();
        check("stall_rd20", OUT, 8'hFA);
        WR = 1'b1; ADRS = 6'h21; IN = 4'h5;
        n++; tick();
        check("stall_prewrite21", OUT, 8'hF0);
        WR = 1'b0;
        n++; tick();
        check("stall_rd21", OUT, 8'hF5);
        ADRS = 6'h01;
        n++; tick();
        check("stall_rd01", OUT, 8'hF9);
        ENABLE = 1'b0;
        while (BUSY === 1'b1 && n < 200) begin n++; tick(); end
        check("stall_busy_len", 8'(n), 8'd23);
        check_reg("stall_reg0", 6'h00, 4'h9);
        check_reg("stall_reg20", 6'h20, 4'hA);

        // Asynchronous reset in the middle of the coin phase.
        COIN = 2'b01;
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        tick();
        RESET_N = 1'b0;
        #2;
        check("midrst_out", OUT, 8'hF0);
        check("midrst_credits", CREDITS, 8'd0);
        check("midrst_busy", {7'd0, BUSY}, 8'd0);
        RESET_N = 1'b1;
        tick();
        run_update("busy_post_rst");
        check("post_rst_credits", CREDITS, 8'd4);
        check_reg("post_rst_reg0", 6'h00, 4'h4);
        check_reg("post_rst_reg20", 6'h20, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
